// File: rtl/conv8_pkg.sv
// conv8_pkg -- shared constants and FSM state type for the 8x8 conv sequencer.
//   Geometry: 8x8 image of 2-bit pixels, 3x3 filter, 6x6 result.
//   Bus widths: ROW_W (one image row), IN_W (whole image), FILT_W, OUT_W.
package conv8_pkg;

  localparam int PIX_W   = 2;
  localparam int IMG_DIM = 8;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = 6;

  localparam int ROW_W  = PIX_W * IMG_DIM;            // 16
  localparam int IN_W   = ROW_W * IMG_DIM;            // 128
  localparam int FILT_W = PIX_W * K_DIM * K_DIM;      // 18
  localparam int OUT_W  = PIX_W * OUT_DIM * OUT_DIM;  // 72

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/conv_8x8_ctrl.sv
// conv_8x8_ctrl -- frame sequencer for the 8x8 convolution array.
//   Collects eight 16-bit row beats into the 128-bit image bus, holds the
//   18-bit filter, waits the array latency, then captures and offers the
//   72-bit result on a valid/ready port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_filter[_we]       filter write (ignored while the array computes)
//   row_valid/ready/data  upstream row stream
//   res_valid/ready/data  result stream
//   busy                  high whenever not IDLE
//   conv_in/conv_filter   buses to the array
//   conv_out              result bus from the array
//   frame_cnt             (CONV_CTRL_FRAME_CNT_EN only) result handshake count
// Build option: define CONV_CTRL_FRAME_CNT_EN to add the frame counter port.
module conv_8x8_ctrl
  import conv8_pkg::*;
#(
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FILT_W-1:0] cfg_filter,
  input  logic              cfg_filter_we,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [ROW_W-1:0]  row_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              busy,
  output logic [IN_W-1:0]   conv_in,
  output logic [FILT_W-1:0] conv_filter,
  input  logic [OUT_W-1:0]  conv_out
`ifdef CONV_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  // The first WAIT cycle is the one in which the completed image bus first
  // reaches the array; counting to MAC_LAT from there places the capture
  // edge MAC_LAT+1 edges after the last row is accepted, i.e. once the
  // array's output for this image is stable.
  localparam logic [3:0] LAT_END = 4'(MAC_LAT);

  state_t     state;
  logic [2:0] row_cnt;
  logic [3:0] lat_cnt;

  assign row_ready = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= 3'd0;
      lat_cnt     <= 4'd0;
      conv_in     <= '0;
      conv_filter <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
    end else begin
      // Filter is frozen while the array computes so the result matches
      // the filter that was on the bus when the image completed.
      if (cfg_filter_we && (state != WAIT))
        conv_filter <= cfg_filter;

      unique case (state)
        IDLE: begin
          if (row_valid) begin
            conv_in[ROW_W-1:0] <= row_data;
            row_cnt            <= 3'd1;
            state              <= LOAD;
          end
        end
        LOAD: begin
          // conv_in is overwritten in place; rows of the previous frame
          // stay visible until replaced.
          if (row_valid) begin
            conv_in[ROW_W*row_cnt +: ROW_W] <= row_data;
            if (row_cnt == 3'd7) begin
              row_cnt <= 3'd0;
              lat_cnt <= 4'd0;
              state   <= WAIT;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAT_END) begin
            res_data  <= conv_out;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_CTRL_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_cnt <= 16'd0;
    else if ((state == DONE) && res_ready)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv_8x8_ctrl.sv
// tb_conv_8x8_ctrl -- scoreboard bench for conv_8x8_ctrl with a stub array
// (conv_out = conv_in[71:0] ^ {4{conv_filter}}, registered MAC_LAT deep).
module tb_conv_8x8_ctrl;
  import conv8_pkg::*;

  localparam int MAC_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [FILT_W-1:0] cfg_filter = '0;
  logic              cfg_filter_we = 1'b0;
  logic              row_valid = 1'b0;
  logic              row_ready;
  logic [ROW_W-1:0]  row_data = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [OUT_W-1:0]  res_data;
  logic              busy;
  logic [IN_W-1:0]   conv_in;
  logic [FILT_W-1:0] conv_filter;
  logic [OUT_W-1:0]  conv_out;
`ifdef CONV_CTRL_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  conv_8x8_ctrl #(.MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_filter(cfg_filter), .cfg_filter_we(cfg_filter_we),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .conv_in(conv_in), .conv_filter(conv_filter),
    .conv_out(conv_out)
`ifdef CONV_CTRL_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // stub array
  logic [OUT_W-1:0] stub_pipe [MAC_LAT];
  always_ff @(posedge clk) begin
    stub_pipe[0] <= conv_in[OUT_W-1:0] ^ {4{conv_filter}};
    for (int i = 1; i < MAC_LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign conv_out = stub_pipe[MAC_LAT-1];

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // bench model
  int               n_vec = 0;
  int               n_err = 0;
  logic [IN_W-1:0]  img_m = '0;
  logic [FILT_W-1:0] filt_m = '0;
  logic [15:0]      fcnt_m = '0;
  int               ridx = 0;
  int               acc_cyc = 0;
  logic [OUT_W-1:0] sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_row(input logic [ROW_W-1:0] d);
    bit ok = 1'b0;
    row_valid = 1'b1;
    row_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = row_ready;
      tick();
    end
    row_valid = 1'b0;
    if (!ok) chk("row_accept_timeout", 128'd0, 128'd1);
    else begin
      img_m[ROW_W*ridx +: ROW_W] = d;
      ridx++;
      if (ridx == 8) begin
        ridx    = 0;
        acc_cyc = cyc;
        sb.push_back(img_m[OUT_W-1:0] ^ {4{filt_m}});
      end
    end
  endtask

  task automatic write_filt(input logic [FILT_W-1:0] d, input bit take);
    cfg_filter    = d;
    cfg_filter_we = 1'b1;
    tick();
    cfg_filter_we = 1'b0;
    if (take) filt_m = d;
    chk("conv_filter", conv_filter, filt_m);
  endtask

  task automatic wait_res();
    for (int i = 0; i < 40 && !res_valid; i++) tick();
    chk("res_valid_rise", res_valid, 1);
    chk("res_latency", cyc - acc_cyc, MAC_LAT + 1);
  endtask

  task automatic take_res();
    logic [OUT_W-1:0] exp;
    if (sb.size() == 0) begin
      chk("sb_empty", 128'd0, 128'd1);
      exp = '0;
    end else exp = sb.pop_front();
    chk("res_data", res_data, exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    fcnt_m++;
    chk("res_valid_clr", res_valid, 0);
    chk("busy_idle", busy, 0);
`ifdef CONV_CTRL_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, fcnt_m);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    img_m = '0; filt_m = '0; ridx = 0; fcnt_m = '0;
    sb.delete();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_row_ready", row_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_conv_in", conv_in, 0);
    chk("rst_conv_filter", conv_filter, 0);
    chk("rst_res_data", res_data, 0);
`ifdef CONV_CTRL_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    do_reset();

    // nominal frame
    write_filt(18'h2AAAA, 1'b1);
    for (int r = 1; r <= 8; r++) send_row(16'(r));
    chk("nom_conv_in", conv_in, img_m);
    chk("nom_busy", busy, 1);
    chk("nom_row_ready_wait", row_ready, 0);
    wait_res();

    // backpressure in DONE with a row offered
    row_valid = 1'b1;
    row_data  = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, sb[0]);
      chk("bp_row_ready", row_ready, 0);
      tick();
    end
    take_res();
    chk("bp_row_ready_idle", row_ready, 1);
    chk("bp_no_row", conv_in, img_m);
    row_valid = 1'b0;
    tick();

    // gapped input + filter freeze during WAIT
    for (int i = 0; i < 8; i++) begin
      send_row((i % 2 == 0) ? 16'hFFFF : 16'h0000);
      if (i < 7) begin tick(); tick(); end
    end
    chk("gap_conv_in", conv_in, img_m);
    write_filt(18'h15555, 1'b0);
    wait_res();
    write_filt(18'h15555, 1'b1);
    chk("done_res_hold", res_valid, 1);
    take_res();

    // mid-frame reset, then fresh frame with filter write on the 8th row
    write_filt(18'h0C3C3, 1'b1);
    for (int r = 0; r < 4; r++) send_row(16'($urandom));
    do_reset();
    write_filt(18'h3C3C3, 1'b1);
    for (int r = 0; r < 7; r++) send_row(16'($urandom));
    cfg_filter    = 18'h21B6D;
    cfg_filter_we = 1'b1;
    filt_m        = 18'h21B6D;
    send_row(16'($urandom));
    cfg_filter_we = 1'b0;
    chk("filt_with_row8", conv_filter, filt_m);
    chk("fresh_conv_in", conv_in, img_m);
    wait_res();
    take_res();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
